// File: rtl/servo_pwm_pkg.sv
// Shared register map, bit positions and measurement FSM encoding for servo_pwm_capture.
package servo_pwm_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_HIGH   = 2'd2;
  localparam logic [1:0] ADDR_PERIOD = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned ST_VALID   = 0;
  localparam int unsigned ST_TIMEOUT = 1;
  localparam int unsigned ST_OVERRUN = 2;

  localparam int unsigned FILT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meas_state_e;

endpackage

// File: rtl/servo_pwm_capture_sync_filter.sv
// Two-flop synchroniser, consecutive-sample glitch filter and registered edge pulses
// for the asynchronous PWM feedback pin.
module pwm_sync_filter
  import servo_pwm_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0]            sync_q;
  logic                  level_q, level_d;
  logic [FILT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  rise_q, fall_q;

  // Level flips only after FILT_LEN consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == FILT_CNT_W'(FILT_LEN - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + FILT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pin_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// Measures high time and period of the servo PWM feedback and exposes the results,
// status flags and a level interrupt through an Avalon-MM slave.
module servo_pwm_capture
  import servo_pwm_pkg::*;
#(
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned TIMEOUT  = 2500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pwm_in,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  logic rise, fall;
  logic wr_en, rd_en;
  logic publish, timeout;
  logic unused_wdata;

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] per_hold_q, per_hold_d;
  logic             held_q, held_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [2:0]       status_q, status_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  pwm_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk    (clk),
    .rst_n  (reset_n),
    .pin_i  (pwm_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign wr_en        = avs_chipselect & avs_write;
  assign rd_en        = avs_chipselect & avs_read;
  assign unused_wdata = ^avs_writedata[31:3];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_lat_d   = hi_lat_q;
    high_d     = high_q;
    period_d   = period_q;
    per_hold_d = per_hold_q;
    held_d     = held_q;
    ctrl_d     = ctrl_q;
    status_d   = status_q;
    rdata_d    = '0;
    publish    = 1'b0;
    timeout    = 1'b0;

    // Measurement FSM; an edge in the timeout cycle takes priority.
    if (ctrl_q[CTRL_EN]) begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) begin
            state_d = HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
        HIGH: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fall) begin
            state_d  = LOW;
            hi_lat_d = cnt_q;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            state_d = IDLE;
            cnt_d   = '0;
            timeout = 1'b1;
          end
        end
        LOW: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (rise) begin
            publish  = 1'b1;
            high_d   = hi_lat_q;
            period_d = cnt_q;
            cnt_d    = CNT_W'(1);
            state_d  = HIGH;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            state_d = IDLE;
            cnt_d   = '0;
            timeout = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    if (wr_en && avs_address == ADDR_CTRL) begin
      ctrl_d = avs_writedata[1:0];
    end
    // W1C first, then set events so a coincident set wins.
    if (wr_en && avs_address == ADDR_STATUS) begin
      status_d = status_q & ~avs_writedata[2:0];
    end
    if (publish) begin
      status_d[ST_VALID] = 1'b1;
      if (status_q[ST_VALID]) begin
        status_d[ST_OVERRUN] = 1'b1;
      end
      held_d = 1'b0;
    end
    if (timeout) begin
      status_d[ST_TIMEOUT] = 1'b1;
    end

    if (rd_en) begin
      unique case (avs_address)
        ADDR_CTRL:   rdata_d = 32'(ctrl_q);
        ADDR_STATUS: rdata_d = 32'(status_q);
        ADDR_HIGH: begin
          rdata_d    = 32'(high_q);
          per_hold_d = period_q;
          held_d     = 1'b1;
        end
        default:     rdata_d = held_q ? 32'(per_hold_q) : 32'(period_q);
      endcase
    end

    irq_d = ctrl_q[CTRL_IRQ_EN] & (status_q[ST_VALID] | status_q[ST_TIMEOUT]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_lat_q   <= '0;
      high_q     <= '0;
      period_q   <= '0;
      per_hold_q <= '0;
      held_q     <= 1'b0;
      ctrl_q     <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_lat_q   <= hi_lat_d;
      high_q     <= high_d;
      period_q   <= period_d;
      per_hold_q <= per_hold_d;
      held_q     <= held_d;
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Scoreboard bench: pin waveforms are described as high/low phase lengths and a
// pulse-level model predicts the register contents; a monitor checks every response.
module tb_servo_pwm_capture;
  import servo_pwm_pkg::*;

  localparam int unsigned TMO = 5000;
  localparam int K_READ = 0, K_IRQ = 1, K_STATE = 2, K_LEVEL = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_chipselect = 1'b0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;

  always #5 clk = ~clk;

  servo_pwm_capture #(.CNT_W(24), .FILT_LEN(4), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pwm_in         (pwm_in),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .irq            (irq)
  );

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t rd_q[$];
  exp_t pr_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rvalid  = 1'b0;

  // Pulse-level reference model
  logic [1:0] m_ctrl;
  bit         m_valid, m_tflag, m_ovr, m_held, m_track;
  int         m_high, m_period, m_hold, cur_h, pend_h, pend_p;

  always @(posedge clk) rvalid <= avs_read & avs_chipselect;

  task automatic score(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t t;
    if (rvalid) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%0h expected no response", avs_readdata);
      end else begin
        t = rd_q.pop_front();
        score(t.name, avs_readdata, t.val);
      end
    end
    while (pr_q.size() != 0) begin
      t = pr_q.pop_front();
      case (t.kind)
        K_IRQ:   score(t.name, 32'(irq), t.val);
        K_STATE: score(t.name, 32'(dut.state_q), t.val);
        default: score(t.name, 32'(dut.u_filt.level_q), t.val);
      endcase
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] m_status();
    return {29'b0, m_ovr, m_tflag, m_valid};
  endfunction

  function automatic logic [31:0] m_irq();
    return 32'(m_ctrl[1] & (m_valid | m_tflag));
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_valid = 0; m_tflag = 0; m_ovr = 0; m_held = 0; m_track = 0;
    m_high = 0; m_period = 0; m_hold = 0; cur_h = 0; pend_h = 0; pend_p = 0;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] d);
    if (a == ADDR_CTRL) begin
      m_ctrl = d[1:0];
      if (!d[0]) m_track = 0;
    end else if (a == ADDR_STATUS) begin
      if (d[0]) m_valid = 0;
      if (d[1]) m_tflag = 0;
      if (d[2]) m_ovr = 0;
    end
  endtask

  task automatic model_publish();
    if (m_valid) m_ovr = 1;
    m_valid  = 1;
    m_high   = pend_h;
    m_period = pend_p;
    m_held   = 0;
  endtask

  task automatic probe(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = kind; e.val = v; e.name = nm;
    pr_q.push_back(e);
    wait_cycles(1);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_chipselect = 1'b1; avs_write = 1'b1;
    @(negedge clk);
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] expv, input string nm);
    exp_t e;
    e.kind = K_READ; e.val = expv; e.name = nm;
    rd_q.push_back(e);
    avs_address = a; avs_chipselect = 1'b1; avs_read = 1'b1;
    @(negedge clk);
    avs_chipselect = 1'b0; avs_read = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus_write(a, d);
    model_write(a, d);
  endtask

  // ops: bit0 read STATUS, bit1 read HIGH_TIME, bit2 read PERIOD, bit3 clear all flags.
  // w1c_pub writes VALID-clear in the cycle the previous pulse is published.
  task automatic high_phase(input int h, input logic [3:0] ops, input bit w1c_pub);
    int used;
    pwm_in = 1'b1;
    wait_cycles(6);
    if (w1c_pub) cfg_write(ADDR_STATUS, 32'h1);
    else wait_cycles(1);
    if (m_track) model_publish();
    m_track = m_ctrl[0];
    cur_h = h;
    used = 7;
    if (ops[0]) begin bus_read(ADDR_STATUS, m_status(), "status"); used++; end
    if (ops[1]) begin
      bus_read(ADDR_HIGH, 32'(m_high), "high_time");
      m_hold = m_period; m_held = 1; used++;
    end
    if (ops[2]) begin
      bus_read(ADDR_PERIOD, 32'(m_held ? m_hold : m_period), "period"); used++;
    end
    if (ops[3]) begin cfg_write(ADDR_STATUS, 32'h7); used++; end
    wait_cycles(h - used);
    if (m_track && h > int'(TMO)) begin m_track = 0; m_tflag = 1; end
  endtask

  task automatic low_phase(input int l);
    pwm_in = 1'b0;
    wait_cycles(l);
    if (m_track) begin
      if (cur_h + l > int'(TMO)) begin
        m_track = 0; m_tflag = 1;
      end else begin
        pend_h = cur_h; pend_p = cur_h + l;
      end
    end
  endtask

  task automatic read_all(input string tag);
    bus_read(ADDR_CTRL, 32'(m_ctrl), {tag, "_ctrl"});
    bus_read(ADDR_STATUS, m_status(), {tag, "_status"});
    bus_read(ADDR_HIGH, 32'(m_high), {tag, "_high"});
    m_hold = m_period; m_held = 1;
    bus_read(ADDR_PERIOD, 32'(m_hold), {tag, "_period"});
  endtask

  initial begin
    int h, l;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(2);
    read_all("reset");
    probe(K_IRQ, m_irq(), "reset_irq");
    probe(K_STATE, 32'(IDLE), "reset_state");

    // Basic measurement: 150 high / 850 low
    cfg_write(ADDR_CTRL, 32'h1);
    high_phase(150, 4'b0000, 0);
    low_phase(850);
    high_phase(150, 4'b0111, 0);
    low_phase(850);

    // Short glitch must not reach the filtered level
    cfg_write(ADDR_CTRL, 32'h0);
    cfg_write(ADDR_STATUS, 32'h7);
    cfg_write(ADDR_CTRL, 32'h1);
    pwm_in = 1'b1;
    wait_cycles(3);
    pwm_in = 1'b0;
    for (int i = 0; i < 10; i++) probe(K_LEVEL, 32'h0, "glitch_level");
    probe(K_STATE, 32'(IDLE), "glitch_state");
    bus_read(ADDR_STATUS, m_status(), "glitch_status");

    // Timeout with interrupt enabled
    cfg_write(ADDR_CTRL, 32'h3);
    bus_read(ADDR_CTRL, 32'(m_ctrl), "ctrl_rw");
    high_phase(6000, 4'b0000, 0);
    probe(K_IRQ, m_irq(), "timeout_irq");
    probe(K_STATE, 32'(IDLE), "timeout_state");
    bus_read(ADDR_STATUS, m_status(), "timeout_status");
    low_phase(100);
    cfg_write(ADDR_STATUS, 32'h2);
    wait_cycles(3);
    probe(K_IRQ, m_irq(), "irq_cleared");
    cfg_write(ADDR_CTRL, 32'h1);

    // Overrun: two publishes without clearing VALID
    high_phase(150, 4'b0000, 0);
    low_phase(850);
    high_phase(300, 4'b0000, 0);
    low_phase(700);
    high_phase(50, 4'b1011, 0);
    low_phase(950);

    // W1C in publish cycle, then HIGH_TIME/PERIOD pair across a publish
    high_phase(150, 4'b0011, 1);
    low_phase(850);
    high_phase(200, 4'b0010, 0);
    low_phase(800);
    high_phase(100, 4'b0100, 0);
    low_phase(900);

    // Period exactly TIMEOUT publishes; one cycle more times out
    high_phase(100, 4'b0000, 0);
    low_phase(4900);
    high_phase(100, 4'b0111, 0);
    low_phase(4901);
    high_phase(100, 4'b0001, 0);
    low_phase(500);
    high_phase(60, 4'b1001, 0);
    low_phase(500);

    // Randomised pulse trains
    for (int i = 0; i < 20; i++) begin
      h = int'($urandom_range(12, 400));
      l = int'($urandom_range(12, 600));
      high_phase(h, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      low_phase(l);
    end
    high_phase(40, 4'b0111, 0);
    low_phase(100);

    // Reset in the middle of a high phase
    pwm_in = 1'b1;
    wait_cycles(40);
    reset_n = 1'b0;
    model_reset();
    wait_cycles(2);
    reset_n = 1'b1;
    pwm_in = 1'b0;
    wait_cycles(2);
    read_all("midreset");
    probe(K_IRQ, m_irq(), "midreset_irq");
    probe(K_STATE, 32'(IDLE), "midreset_state");

    wait_cycles(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
